// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32 x XLEN register file with WB bypass and a load-use busy scoreboard
module regfile_scoreboard #(
    parameter int XLEN      = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic [4:0]      i_id_rs1,
    input  logic [4:0]      i_id_rs2,
    input  logic            i_id_use_rs1,
    input  logic            i_id_use_rs2,
    input  logic            i_id_issue,
    input  logic [4:0]      i_id_issue_rd,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_id_rs1_data,
    output logic [XLEN-1:0] o_id_rs2_data,
    output logic            o_id_rs1_busy,
    output logic            o_id_rs2_busy,
    output logic            o_id_stall
);
    logic [XLEN-1:0] regs [32];
    logic [31:0] busy, busy_nxt;
    logic hit1, hit2;
    // issue is applied after the WB clear so the newer owner keeps the bit; flush overrides both
    always_comb begin
        busy_nxt = busy;
        if (i_wb_we) busy_nxt[i_wb_rd] = 1'b0;
        if (i_id_issue) busy_nxt[i_id_issue_rd] = 1'b1;
        if (i_flush) busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            busy <= busy_nxt;
            if (i_wb_we && i_wb_rd != 5'd0) regs[i_wb_rd] <= i_wb_data;
        end
    end
    assign hit1 = BYPASS_EN && i_wb_we && i_wb_rd == i_id_rs1;
    assign hit2 = BYPASS_EN && i_wb_we && i_wb_rd == i_id_rs2;
    assign o_id_rs1_data = (i_id_rs1 == 5'd0) ? '0 : hit1 ? i_wb_data : regs[i_id_rs1];
    assign o_id_rs2_data = (i_id_rs2 == 5'd0) ? '0 : hit2 ? i_wb_data : regs[i_id_rs2];
    assign o_id_rs1_busy = busy[i_id_rs1] && i_id_rs1 != 5'd0 && !hit1;
    assign o_id_rs2_busy = busy[i_id_rs2] && i_id_rs2 != 5'd0 && !hit2;
    assign o_id_stall = (i_id_use_rs1 && o_id_rs1_busy) || (i_id_use_rs2 && o_id_rs2_busy);
endmodule
